fixed_addsub_pipe: RTL and testbench

Parametrised, pipelined fixed-point add/subtract/accumulate unit for the fixed-point ALU. Generalises the combinational 32-bit adder to any WIDTH/FRAC format. Adds a valid/ready handshake, selectable saturation or wrap, a running accumulator, and a sticky overflow flag. It sits between the calculator's operand sequencer and the result/display path.

---
 rtl/fixed_pkg.sv | 27 ++
 rtl/fixed_sat_add.sv | 39 +++
 rtl/fixed_addsub_pipe.sv | 142 ++++++++++++++
 tb/tb_fixed_addsub_pipe.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared definitions for the fixed-point add/sub/accumulate unit:
// operation encodings and two's-complement extreme-value helpers.
package fixed_pkg;

  // Widest format the extreme-value helpers can describe.
  localparam int unsigned FX_MAX_W = 64;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,  // a + b
    OP_SUB  = 2'b01,  // a - b
    OP_ACC  = 2'b10,  // acc + a
    OP_LOAD = 2'b11   // acc = a
  } op_e;

  // Largest positive value of a width-bit two's-complement number
  // (0 followed by ones), right-aligned in FX_MAX_W bits.
  function automatic logic [FX_MAX_W-1:0] fx_max(input int unsigned width);
    return (FX_MAX_W'(1) << (width - 1)) - FX_MAX_W'(1);
  endfunction

  // Most negative value of a width-bit two's-complement number
  // (1 followed by zeros), right-aligned in FX_MAX_W bits.
  function automatic logic [FX_MAX_W-1:0] fx_min(input int unsigned width);
    return FX_MAX_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/fixed_sat_add.sv
// Combinational WIDTH-bit two's-complement add/subtract with overflow
// detection and optional saturation. The operation is done in WIDTH+1
// bits so that subtracting the most negative value is exact.
module fixed_sat_add
  import fixed_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SAT_EN = 1
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(fx_max(WIDTH));
  localparam logic [WIDTH-1:0] L_MIN = WIDTH'(fx_min(WIDTH));

  logic [WIDTH:0] w_xe;
  logic [WIDTH:0] w_ye;
  logic [WIDTH:0] w_sum;

  assign w_xe  = {i_x[WIDTH-1], i_x};
  assign w_ye  = {i_y[WIDTH-1], i_y};
  assign w_sum = i_sub ? (w_xe - w_ye) : (w_xe + w_ye);

  // The two top bits disagree exactly when the result does not fit WIDTH bits.
  assign o_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];

  // Clamp towards the sign of the true (WIDTH+1-bit) result, or wrap.
  always_comb begin
    o_sum = w_sum[WIDTH-1:0];
    if ((SAT_EN != 0) && o_ovf) begin
      o_sum = w_sum[WIDTH] ? L_MIN : L_MAX;
    end
  end

endmodule

// File: rtl/fixed_addsub_pipe.sv
// Two-stage pipelined fixed-point add/subtract/accumulate unit.
// Stage 1 captures the operand beat, stage 2 computes the result, updates
// the accumulator and the sticky overflow flag.
//
// Handshake: a beat moves on an edge where valid && ready are both high.
// Upstream holds in_valid/a/b/op stable until it sees in_ready high at an
// edge; downstream holds nothing, it simply raises out_ready when it takes
// result. The whole pipe advances whenever the output register is empty or
// being consumed, so in_ready is purely a function of out_valid/out_ready.
module fixed_addsub_pipe
  import fixed_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 16,
  parameter int SAT_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  // FRAC only names the binary-point position; add/sub do not depend on it.
  if (WIDTH < 4 || FRAC < 0 || FRAC >= WIDTH) begin : g_bad_format
    $error("fixed_addsub_pipe: need WIDTH >= 4 and 0 <= FRAC < WIDTH");
  end

  // Stage 1 registers
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  op_e              r_op;
  logic             r_v1;

  // Stage 2 / architectural state
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_overflow;
  logic             r_ovf_sticky;
  logic [WIDTH-1:0] r_acc;

  logic             w_adv;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic             w_is_acc_op;
  logic             w_fire2;

  assign w_adv       = !r_out_valid || out_ready;
  assign w_is_acc_op = (r_op == OP_ACC) || (r_op == OP_LOAD);
  assign w_fire2     = w_adv && r_v1;

  // Route stage-1 operands into the shared adder according to the opcode.
  always_comb begin
    w_x   = r_a;
    w_y   = r_b;
    w_sub = 1'b0;
    case (r_op)
      OP_ADD:  w_sub = 1'b0;
      OP_SUB:  w_sub = 1'b1;
      OP_ACC: begin
        w_x = r_acc;
        w_y = r_a;
      end
      OP_LOAD: w_y = '0;  // a + 0 never overflows
      default: w_sub = 1'b0;
    endcase
  end

  fixed_sat_add #(
    .WIDTH  (WIDTH),
    .SAT_EN (SAT_EN)
  ) u_sat_add (
    .i_x   (w_x),
    .i_y   (w_y),
    .i_sub (w_sub),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  // Stage 1: capture the beat when the pipe advances; no accept = bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= OP_ADD;
      r_v1 <= 1'b0;
    end else if (w_adv) begin
      r_a  <= a;
      r_b  <= b;
      r_op <= op_e'(op);
      r_v1 <= in_valid;
    end
  end

  // Stage 2: register the result and update the accumulator for ACC/LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_acc       <= '0;
    end else if (w_adv) begin
      r_out_valid <= r_v1;
      if (r_v1) begin
        r_result   <= w_sum;
        r_overflow <= w_ovf;
        if (w_is_acc_op) begin
          r_acc <= w_sum;
        end
      end
    end
  end

  // Sticky overflow: a new overflow beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_fire2 && w_ovf) begin
      r_ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  assign in_ready   = w_adv;
  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign overflow   = r_overflow;
  assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_fixed_addsub_pipe.sv
// Directed bench for fixed_addsub_pipe: a saturating and a wrapping
// instance are driven with identical stimulus and checked against
// hand-computed Q16.16 vectors plus hand-written pipeline sequences.
module tb_fixed_addsub_pipe;
  import fixed_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid, out_ready, clr_sticky;
  logic [W-1:0] a, b;
  logic [1:0]   op;
  logic         in_ready, out_valid, overflow, ovf_sticky;
  logic [W-1:0] result;
  logic         in_ready_w, out_valid_w, overflow_w, ovf_sticky_w;
  logic [W-1:0] result_w;

  fixed_addsub_pipe #(.WIDTH(W), .FRAC(16), .SAT_EN(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .ovf_sticky(ovf_sticky),
    .clr_sticky(clr_sticky)
  );

  fixed_addsub_pipe #(.WIDTH(W), .FRAC(16), .SAT_EN(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .op(op), .out_valid(out_valid_w), .out_ready(out_ready),
    .result(result_w), .overflow(overflow_w), .ovf_sticky(ovf_sticky_w),
    .clr_sticky(clr_sticky)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W:0] exp_q[$];    // {overflow, result} for the saturating unit
  logic [W:0] exp_w_q[$];  // {overflow, result} for the wrapping unit
  int   cyc = 0;
  int   last_cyc = -1;
  logic chk_gap = 1'b0;
  logic [W:0] e_s, e_w;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Pop and compare every transferred result; sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_ready === 1'b1) begin
      if (out_valid === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sat_unexpected: got %h ovf %b, expected no result", result, overflow);
        end else begin
          e_s = exp_q.pop_front();
          if ({overflow, result} !== e_s) begin
            n_fail++;
            $display("FAIL sat_result: got ovf %b res %h, expected ovf %b res %h",
                     overflow, result, e_s[W], e_s[W-1:0]);
          end
        end
        if (chk_gap) begin
          if (last_cyc >= 0) begin
            n_tests++;
            if (cyc != last_cyc + 1) begin
              n_fail++;
              $display("FAIL stream_gap: got result at cycle %0d, expected cycle %0d", cyc, last_cyc + 1);
            end
          end
          last_cyc = cyc;
        end
      end
      if (out_valid_w === 1'b1) begin
        n_tests++;
        if (exp_w_q.size() == 0) begin
          n_fail++;
          $display("FAIL wrap_unexpected: got %h ovf %b, expected no result", result_w, overflow_w);
        end else begin
          e_w = exp_w_q.pop_front();
          if ({overflow_w, result_w} !== e_w) begin
            n_fail++;
            $display("FAIL wrap_result: got ovf %b res %h, expected ovf %b res %h",
                     overflow_w, result_w, e_w[W], e_w[W-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present one beat and hold it until accepted; queue its expected results.
  task automatic send(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W:0] es, input logic [W:0] ew);
    logic got;
    in_valid = 1'b1;
    op = o;
    a  = av;
    b  = bv;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 for 50 cycles, expected 1");
    end else begin
      exp_q.push_back(es);
      exp_w_q.push_back(ew);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a  = '0;
    b  = '0;
    op = 2'b00;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 30 && (exp_q.size() != 0 || exp_w_q.size() != 0); k++) @(posedge clk);
    #1;
    check({name, "_sat_pending"}, (W+1)'(exp_q.size()), '0);
    check({name, "_wrap_pending"}, (W+1)'(exp_w_q.size()), '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res_s;
    logic         ovf_s;
    logic [W-1:0] res_w;
    logic         ovf_w;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] rs, input logic os,
                         input logic [W-1:0] rw, input logic ow);
    vec_t v;
    v.op = o; v.a = av; v.b = bv;
    v.res_s = rs; v.ovf_s = os; v.res_w = rw; v.ovf_w = ow;
    vecs.push_back(v);
  endtask

  logic [W-1:0] hold_res;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    a = '0; b = '0; op = 2'b00;

    //                op       a             b             sat res       ovf   wrap res      ovf
    add_vec(OP_ADD,  32'h0001_8000, 32'h0002_4000, 32'h0003_C000, 1'b0, 32'h0003_C000, 1'b0);
    add_vec(OP_ADD,  32'h7FFF_0000, 32'h0001_0000, 32'h7FFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
    add_vec(OP_SUB,  32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
    add_vec(OP_SUB,  32'hFFFF_0000, 32'h7FFF_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0);
    add_vec(OP_ADD,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1);
    add_vec(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
    add_vec(OP_SUB,  32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000, 1'b0, 32'hFFFF_0000, 1'b0);
    add_vec(OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1);
    add_vec(OP_LOAD, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0001_0000, 1'b0, 32'h0001_0000, 1'b0);
    add_vec(OP_ACC,  32'h0000_8000, 32'h1234_5678, 32'h0001_8000, 1'b0, 32'h0001_8000, 1'b0);
    add_vec(OP_ACC,  32'h0000_8000, 32'h0000_0000, 32'h0002_0000, 1'b0, 32'h0002_0000, 1'b0);
    add_vec(OP_ACC,  32'h0000_8000, 32'h0000_0000, 32'h0002_8000, 1'b0, 32'h0002_8000, 1'b0);
    add_vec(OP_LOAD, 32'h7FFF_0000, 32'h0000_0000, 32'h7FFF_0000, 1'b0, 32'h7FFF_0000, 1'b0);
    add_vec(OP_ACC,  32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
    add_vec(OP_ACC,  32'h0000_0001, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 32'h8000_0001, 1'b0);
    add_vec(OP_ACC,  32'hFFFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFE, 1'b0, 32'h8000_0000, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", (W+1)'(out_valid), '0);
    check("rst_result", (W+1)'(result), '0);
    check("rst_overflow", (W+1)'(overflow), '0);
    check("rst_sticky", (W+1)'(ovf_sticky), '0);
    check("rst_in_ready", (W+1)'(in_ready), (W+1)'(1));
    @(posedge clk); #1;

    // Latency: nothing after the accept edge, result after the next one.
    send(OP_ADD, 32'h0001_8000, 32'h0002_4000, {1'b0, 32'h0003_C000}, {1'b0, 32'h0003_C000});
    idle();
    @(negedge clk);
    check("lat_edge1_valid", (W+1)'(out_valid), '0);
    @(negedge clk);
    check("lat_edge2_valid", (W+1)'(out_valid), (W+1)'(1));
    drain("latency");

    // Table, streamed back to back: results must come out on consecutive cycles.
    @(posedge clk); #1;
    last_cyc = -1;
    chk_gap  = 1'b1;
    foreach (vecs[i])
      send(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].ovf_s, vecs[i].res_s},
           {vecs[i].ovf_w, vecs[i].res_w});
    idle();
    drain("table");
    chk_gap = 1'b0;
    check("table_sticky_sat", (W+1)'(ovf_sticky), (W+1)'(1));
    check("table_sticky_wrap", (W+1)'(ovf_sticky_w), (W+1)'(1));

    // Sticky clear alone, then clear coinciding with an overflowing result.
    @(posedge clk); #1 clr_sticky = 1'b1;
    @(posedge clk); #1 clr_sticky = 1'b0;
    @(negedge clk);
    check("clr_sticky_sat", (W+1)'(ovf_sticky), '0);
    check("clr_sticky_wrap", (W+1)'(ovf_sticky_w), '0);
    @(posedge clk); #1;
    send(OP_ADD, 32'h7FFF_0000, 32'h0001_0000, {1'b1, 32'h7FFF_FFFF}, {1'b1, 32'h8000_0000});
    idle();
    clr_sticky = 1'b1;
    @(posedge clk); #1 clr_sticky = 1'b0;
    @(negedge clk);
    check("set_wins_sat", (W+1)'(ovf_sticky), (W+1)'(1));
    check("set_wins_wrap", (W+1)'(ovf_sticky_w), (W+1)'(1));
    drain("sticky");

    // Back-pressure: out_ready low for 3 edges while 4 beats stream in.
    @(posedge clk); #1;
    fork
      begin
        send(OP_ADD, 32'h0000_0001, 32'h0000_0002, {1'b0, 32'h0000_0003}, {1'b0, 32'h0000_0003});
        send(OP_ADD, 32'h0000_0010, 32'h0000_0020, {1'b0, 32'h0000_0030}, {1'b0, 32'h0000_0030});
        send(OP_ADD, 32'h7FFF_0000, 32'h0001_0000, {1'b1, 32'h7FFF_FFFF}, {1'b1, 32'h8000_0000});
        send(OP_SUB, 32'h0000_0005, 32'h0000_0007, {1'b0, 32'hFFFF_FFFE}, {1'b0, 32'hFFFF_FFFE});
        idle();
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp_in_ready_low", (W+1)'(in_ready), '0);
        check("bp_out_valid_high", (W+1)'(out_valid), (W+1)'(1));
        hold_res = result;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_result_hold", (W+1)'(result), (W+1)'(hold_res));
        check("bp_in_ready_still_low", (W+1)'(in_ready), '0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("backpressure");

    // Reset with two beats in flight; accumulator must come back cleared.
    @(posedge clk); #1;
    send(OP_ADD, 32'h7FFF_0000, 32'h0001_0000, {1'b1, 32'h7FFF_FFFF}, {1'b1, 32'h8000_0000});
    send(OP_ADD, 32'h0000_0001, 32'h0000_0001, {1'b0, 32'h0000_0002}, {1'b0, 32'h0000_0002});
    idle();
    check("pre_rst_sticky", (W+1)'(ovf_sticky), (W+1)'(1));
    #1 rst_n = 1'b0;
    exp_q.delete();
    exp_w_q.delete();
    #1;
    check("midrst_out_valid", (W+1)'(out_valid), '0);
    check("midrst_sticky", (W+1)'(ovf_sticky), '0);
    check("midrst_result", (W+1)'(result), '0);
    check("midrst_in_ready", (W+1)'(in_ready), (W+1)'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", (W+1)'(out_valid), '0);
    @(posedge clk); #1;
    send(OP_ACC, 32'h0000_1000, 32'h0000_0000, {1'b0, 32'h0000_1000}, {1'b0, 32'h0000_1000});
    idle();
    drain("post_reset");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got no completion by 200000 time units, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
